// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared pipeline register types, load/store encodings and MEM-stage state
package memory_access_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] instrAddr;
    logic [63:0] aluOut;
    logic        isMemRead;
    logic        isMemWrite;
    logic [2:0]  memFunct3;
    logic [63:0] storeData;
    logic        isWriteBack;
    logic [4:0]  wd;
  } REG_EX_MEM;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] instrAddr;
    logic [63:0] aluOut;
    logic        isWriteBack;
    logic [4:0]  wd;
    logic        isMemRead;
    logic [63:0] memOut;
  } REG_MEM_WB;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Byte-lane mask for an access of the given size, before shifting to the offset
  function automatic logic [7:0] size_mask(input mem_size_t sz);
    return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0F : 8'hFF;
  endfunction

endpackage

// File: rtl/memory_access_align.sv
// memory_access_align: store lane/strobe placement and load shift with sign/zero extension
module mem_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  input  logic [63:0] load_word,
  output logic [7:0]  strobe,
  output logic [63:0] wdata,
  output logic [63:0] rdata
);

  logic [63:0] raw;

  // Lanes past byte 7 fall off the top; misaligned accesses are simply truncated
  always_comb begin
    strobe = size_mask(mem_size_t'(funct3[1:0])) << offset;
    wdata  = store_data << {offset, 3'b000};
    raw    = load_word >> {offset, 3'b000};
    rdata  = funct3 == F3_LB  ? {{56{raw[7]}}, raw[7:0]} :
             funct3 == F3_LH  ? {{48{raw[15]}}, raw[15:0]} :
             funct3 == F3_LW  ? {{32{raw[31]}}, raw[31:0]} :
             funct3 == F3_LBU ? {56'd0, raw[7:0]} :
             funct3 == F3_LHU ? {48'd0, raw[15:0]} :
             funct3 == F3_LWU ? {32'd0, raw[31:0]} :
             funct3 == F3_LD  ? raw : raw;
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline MEM stage issuing one data-bus access per instruction
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DBUS_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  REG_EX_MEM         moduleIn,
  output REG_MEM_WB         moduleOut,
  output logic              ok_to_proceed,
  input  logic              ok_to_proceed_overall,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DBUS_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [DBUS_W-1:0] dresp_data
);

  mem_state_t  state;
  logic [63:0] load_word;
  logic [7:0]  st_strobe;
  logic [63:0] st_data;
  logic [63:0] ld_data;
  logic        is_mem;
  logic        pending;

  mem_align u_align (
    .offset     (moduleIn.aluOut[2:0]),
    .funct3     (moduleIn.memFunct3),
    .store_data (moduleIn.storeData),
    .load_word  (load_word),
    .strobe     (st_strobe),
    .wdata      (st_data),
    .rdata      (ld_data)
  );

  // DONE doubles as the "already issued" marker, so a stall in DONE never re-issues
  always_comb begin
    is_mem        = moduleIn.isMemRead | moduleIn.isMemWrite;
    pending       = moduleIn.valid & is_mem & (state == IDLE);
    ok_to_proceed = !moduleIn.valid | !is_mem | (state == DONE);
  end

  // Request FSM: issue once, hold the request until the bus answers, then wait for advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      load_word   <= '0;
    end else begin
      case (state)
        IDLE: if (pending) begin
          state       <= BUSY;
          dreq_valid  <= 1'b1;
          dreq_addr   <= moduleIn.aluOut;
          dreq_size   <= {1'b0, moduleIn.memFunct3[1:0]};
          dreq_strobe <= moduleIn.isMemWrite ? st_strobe : 8'h00;
          dreq_data   <= moduleIn.isMemWrite ? st_data : 64'd0;
        end
        BUSY: if (dresp_data_ok) begin
          state      <= DONE;
          dreq_valid <= 1'b0;
          load_word  <= dresp_data;
        end
        DONE: if (ok_to_proceed_overall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback payload only moves on a global advance so it stays stable through stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      moduleOut <= '0;
    end else if (ok_to_proceed_overall) begin
      moduleOut.valid       <= moduleIn.valid;
      moduleOut.instr       <= moduleIn.instr;
      moduleOut.instrAddr   <= moduleIn.instrAddr;
      moduleOut.aluOut      <= moduleIn.aluOut;
      moduleOut.isWriteBack <= moduleIn.isWriteBack;
      moduleOut.wd          <= moduleIn.wd;
      moduleOut.isMemRead   <= moduleIn.isMemRead;
      moduleOut.memOut      <= moduleIn.isMemRead ? ld_data : 64'd0;
    end
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline MEM stage. Sits between execute (REG_EX_MEM) and writeback (REG_MEM_WB).
- Issues at most one data-bus transaction per instruction and aligns/extends load data.
- Builds store byte-lane strobes and data.
- Participates in the global ok_to_proceed stall handshake.

Parameters:
- DBUS_W, 64, data bus width in bits (only 64 supported).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- moduleIn  in  REG_EX_MEM  execute result: valid, instr, instrAddr, aluOut (effective address / ALU result), isMemRead, isMemWrite, memFunct3, storeData, isWriteBack, wd.
- moduleOut  out  REG_MEM_WB  registered payload to writeback.
- ok_to_proceed  out  1  stage has finished its work for the current moduleIn.
- ok_to_proceed_overall  in  1  AND of all stages' ok_to_proceed; pipeline advances this edge.
- dreq_valid  out  1  data request valid.
- dreq_addr  out  64  byte address.
- dreq_size  out  3  0=1B, 1=2B, 2=4B, 3=8B.
- dreq_strobe  out  8  byte write enables; 0 for loads.
- dreq_data  out  64  lane-aligned store data.
- dresp_data_ok  in  1  transaction complete this cycle.
- dresp_data  in  64  raw 64-bit aligned load word.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, dreq_valid=0, all dreq_* = 0, moduleOut all fields 0 (valid=0), captured load data=0.
- A memory op is pending when moduleIn.valid & (isMemRead | isMemWrite) & FSM=IDLE & !done_flag.
- FSM states:
  - IDLE: on a pending memory op, go to BUSY next edge with dreq_* registered from moduleIn. Non-memory instructions never leave IDLE.
  - BUSY: dreq_valid=1, all dreq fields held stable. On dresp_data_ok=1, capture dresp_data, dreq_valid=0 next cycle, go to DONE.
  - DONE: hold captured data. On ok_to_proceed_overall=1, go to IDLE.
- ok_to_proceed is combinational:
  - 1 if !moduleIn.valid, or the instruction is non-memory, or FSM=DONE.
  - 0 if FSM=BUSY, or a memory op is pending in IDLE.
- Minimum latency for a memory op: 1 cycle to issue, plus bus latency, plus 1 (DONE).
- Data-bus handshake: the request is issued only once. Because FSM=DONE blocks re-issue until advance, a global stall while in DONE never causes a second access.
- Address/size: dreq_addr=aluOut. dreq_size=memFunct3[1:0]. Offset o=aluOut[2:0].
- Stores:
  - strobe = (size mask) << o.
  - dreq_data = storeData << (8*o).
  - Size mask values: 0x01, 0x03, 0x0F, 0xFF.
- Loads: raw = dresp_data >> (8*o), then by memFunct3:
  - 000 LB, 001 LH, 010 LW: sign-extend 8/16/32.
  - 011 LD: pass.
  - 100 LBU, 101 LHU, 110 LWU: zero-extend.
  - 111: treat as LD.
- Misaligned accesses: no trap. Bytes shifted beyond bit 63 are dropped. Not architecturally supported.
- Output register (on ok_to_proceed_overall=1 edge):
  - moduleOut.valid <= moduleIn.valid.
  - Copy instr, instrAddr, aluOut, isWriteBack, wd, isMemRead.
  - memOut <= extended load data (0 for non-loads).
- When ok_to_proceed_overall=0: moduleOut held unchanged, so writeback sees a stable payload during stalls.
- Simultaneous events:
  - dresp_data_ok and ok_to_proceed_overall arriving in the same cycle: data is captured, and the pipeline does not advance that edge (ok_to_proceed was 0). Advance occurs from DONE.
  - A new pending op the edge after leaving DONE: issues normally from IDLE.
- rst asserted mid-transaction: request is abandoned. dreq_valid drops asynchronously and the FSM goes to IDLE. The bus is required to be reset in the same domain.

Decomposition:
- In common package:
  - REG_EX_MEM and REG_MEM_WB structs.
  - mem_size_t enum.
  - Funct3 load/store constants (F3_LB…F3_LWU).
  - MEM_STATE enum {IDLE, BUSY, DONE}.
- One natural sub-module, mem_align: purely combinational.
  - Store strobe/data generation.
  - Load shift + extension.
  - Shared with any future cache path.

Test Plan:
- Reset: hold rst=0, then release. Expect moduleOut.valid=0, dreq_valid=0, ok_to_proceed=1 with moduleIn.valid=0.
- ALU op (isWriteBack=1, aluOut=0x2A), overall=1 every cycle. Expect no dreq_valid, moduleOut.aluOut=0x2A, valid=1 one cycle later.
- LB at addr 0x1003, dresp_data=0x00000000_80FF0000 after 3 cycles:
  - ok_to_proceed=0 for 4 cycles; dreq_size=0.
  - memOut=0xFFFFFFFF_FFFFFF80.
  - Repeated as LBU: memOut=0x80.
- SH at addr 0x1006, storeData=0xBEEF. Expect dreq_strobe=0xC0, dreq_data=0xBEEF0000_00000000, exactly one dreq_valid pulse sequence.
- LW completes (DONE) while overall held 0 for 5 cycles, then 1. Expect no second request, moduleOut unchanged during stall, single advance.
- Assert rst=0 while BUSY. Expect dreq_valid=0 immediately (same cycle, no clock). After release, the FSM is IDLE and a re-presented LD issues fresh.
